stall_ctrl: RTL and testbench

- Hazard and stall controller for the 5-stage MIPS pipeline.
- Decodes the instructions held in the D, E and M stage registers and detects RAW hazards that forwarding cannot cover.
- Tracks the multi-cycle multiply/divide unit through an internal busy timer.
- Drives the hold/clear controls of the PC, IF/ID and ID/EX registers. EX/MEM and MEM/WB are never held or cleared by this block.

---
 rtl/mips_pkg.sv | 112 +++++++++++
 rtl/md_busy_timer.sv | 44 ++++
 rtl/stall_ctrl.sv | 79 +++++++
 tb/tb_stall_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_pkg
// Purpose  : Shared MIPS opcode/funct constants and hazard decode helper.
// Revision : 1.0
// ============================================================================
package mips_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2b;

  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_MFHI    = 6'h10;
  localparam logic [5:0] FN_MTHI    = 6'h11;
  localparam logic [5:0] FN_MFLO    = 6'h12;
  localparam logic [5:0] FN_MTLO    = 6'h13;
  localparam logic [5:0] FN_MULT    = 6'h18;
  localparam logic [5:0] FN_MULTU   = 6'h19;
  localparam logic [5:0] FN_DIV     = 6'h1a;
  localparam logic [5:0] FN_DIVU    = 6'h1b;
  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUBU    = 6'h23;

  localparam logic [1:0] T_0 = 2'd0;
  localparam logic [1:0] T_1 = 2'd1;
  localparam logic [1:0] T_2 = 2'd2;

  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef struct packed {
    logic [4:0] rs;
    logic       use_rs;
    logic [1:0] tuse_rs;
    logic [4:0] rt;
    logic       use_rt;
    logic [1:0] tuse_rt;
    logic [4:0] dest;
    logic [1:0] tnew_e;
    logic [1:0] tnew_m;
    logic       md_start;
    logic       is_div;
    logic       is_hilo;
  } dec_t;

  // Unrecognised encodings fall through with no sources and no destination.
  function automatic dec_t decode(input logic [5:0] op, input logic [5:0] fn,
                                  input logic [4:0] rs, input logic [4:0] rt,
                                  input logic [4:0] rd);
    dec_t d;
    d    = '0;
    d.rs = rs;
    d.rt = rt;
    case (op)
      OP_SPECIAL: begin
        case (fn)
          FN_ADDU, FN_SUBU: begin
            d.use_rs = 1'b1; d.tuse_rs = T_1;
            d.use_rt = 1'b1; d.tuse_rt = T_1;
            d.dest   = rd;   d.tnew_e  = T_1;
          end
          FN_JR: begin
            d.use_rs = 1'b1; d.tuse_rs = T_0;
          end
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
            d.use_rs   = 1'b1; d.tuse_rs = T_1;
            d.use_rt   = 1'b1; d.tuse_rt = T_1;
            d.md_start = 1'b1;
            d.is_div   = (fn == FN_DIV) || (fn == FN_DIVU);
            d.is_hilo  = 1'b1;
          end
          FN_MFHI, FN_MFLO: begin
            d.dest = rd; d.tnew_e = T_1; d.is_hilo = 1'b1;
          end
          FN_MTHI, FN_MTLO: begin
            d.use_rs = 1'b1; d.tuse_rs = T_1; d.is_hilo = 1'b1;
          end
          default: ;
        endcase
      end
      OP_ORI: begin
        d.use_rs = 1'b1; d.tuse_rs = T_1;
        d.dest   = rt;   d.tnew_e  = T_1;
      end
      OP_LUI: begin
        d.dest = rt; d.tnew_e = T_1;
      end
      OP_LW: begin
        d.use_rs = 1'b1; d.tuse_rs = T_1;
        d.dest   = rt;   d.tnew_e  = T_2; d.tnew_m = T_1;
      end
      OP_SW: begin
        d.use_rs = 1'b1; d.tuse_rs = T_1;
        d.use_rt = 1'b1; d.tuse_rt = T_2;
      end
      OP_BEQ: begin
        d.use_rs = 1'b1; d.tuse_rs = T_0;
        d.use_rt = 1'b1; d.tuse_rt = T_0;
      end
      OP_JAL: d.dest = 5'd31;
      default: ;
    endcase
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/md_busy_timer.sv
`default_nettype none
// ============================================================================
// Module   : md_busy_timer
// Purpose  : Busy countdown for the multi-cycle mult/div unit, with done pulse.
// Revision : 1.0
// ============================================================================
module md_busy_timer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic md_start,
  input  logic is_div,
  output logic md_busy,
  output logic md_done
);

  localparam logic [CNT_W-1:0] c_mult_load = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] c_div_load  = CNT_W'(DIV_CYCLES);

  logic [CNT_W-1:0] r_cnt;
  logic             r_done;

  // A start while still counting simply reloads; the stall logic prevents it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= (r_cnt == CNT_W'(1)) && !md_start;
      if (md_start)
        r_cnt <= is_div ? c_div_load : c_mult_load;
      else if (r_cnt != '0)
        r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign md_busy = md_start | (r_cnt != '0);
  assign md_done = r_done;

endmodule
`default_nettype wire

// File: rtl/stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : stall_ctrl
// Purpose  : RAW/mult-div hazard detection driving PC, IF/ID and ID/EX control.
// Revision : 1.0
// ============================================================================
module stall_ctrl
  import mips_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IR_D,
  input  logic [31:0] IR_E,
  input  logic [31:0] IR_M,
  output logic        en_PC,
  output logic        en_D,
  output logic        clr_E,
  output logic        md_busy,
  output logic        md_done,
  output logic [31:0] stall_cycles
);

  dec_t        w_dec_d, w_dec_e, w_dec_m;
  logic        w_stall_rs, w_stall_rt, w_data_stall, w_md_stall, w_stall;
  logic        w_md_busy;
  logic [31:0] r_stall_cycles;
  logic        w_unused;

  assign w_dec_d = decode(IR_D[31:26], IR_D[5:0], IR_D[25:21], IR_D[20:16], IR_D[15:11]);
  assign w_dec_e = decode(IR_E[31:26], IR_E[5:0], IR_E[25:21], IR_E[20:16], IR_E[15:11]);
  assign w_dec_m = decode(IR_M[31:26], IR_M[5:0], IR_M[25:21], IR_M[20:16], IR_M[15:11]);

  // Register 0 never carries a dependency, and non-writers have dest 0.
  assign w_stall_rs = w_dec_d.use_rs && (w_dec_d.rs != 5'd0) &&
                      (((w_dec_d.rs == w_dec_e.dest) && (w_dec_e.tnew_e > w_dec_d.tuse_rs)) ||
                       ((w_dec_d.rs == w_dec_m.dest) && (w_dec_m.tnew_m > w_dec_d.tuse_rs)));
  assign w_stall_rt = w_dec_d.use_rt && (w_dec_d.rt != 5'd0) &&
                      (((w_dec_d.rt == w_dec_e.dest) && (w_dec_e.tnew_e > w_dec_d.tuse_rt)) ||
                       ((w_dec_d.rt == w_dec_m.dest) && (w_dec_m.tnew_m > w_dec_d.tuse_rt)));
  assign w_data_stall = w_stall_rs | w_stall_rt;

  md_busy_timer #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_md_busy_timer (
    .clk      (clk),
    .reset    (reset),
    .md_start (w_dec_e.md_start),
    .is_div   (w_dec_e.is_div),
    .md_busy  (w_md_busy),
    .md_done  (md_done)
  );

  assign w_md_stall = w_dec_d.is_hilo & w_md_busy;
  assign w_stall    = w_data_stall | w_md_stall;

  assign en_PC   = ~w_stall;
  assign en_D    = ~w_stall;
  assign clr_E   = w_stall;
  assign md_busy = w_md_busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_stall_cycles <= '0;
    else if (w_stall && (r_stall_cycles != 32'hFFFF_FFFF))
      r_stall_cycles <= r_stall_cycles + 32'd1;
  end

  assign stall_cycles = r_stall_cycles;

  assign w_unused = ^{w_dec_d, w_dec_e, w_dec_m, IR_D[10:6], IR_E[10:6], IR_M[10:6]};

endmodule
`default_nettype wire

// File: tb/tb_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_stall_ctrl
// Purpose  : Directed self-checking bench for stall_ctrl with a cycle model.
// Revision : 1.0
// ============================================================================
module tb_stall_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] IR_D, IR_E, IR_M;
  logic        en_PC, en_D, clr_E, md_busy, md_done;
  logic [31:0] stall_cycles;

  int n_vec = 0;
  int n_bad = 0;

  stall_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .IR_D(IR_D), .IR_E(IR_E), .IR_M(IR_M),
    .en_PC(en_PC), .en_D(en_D), .clr_E(clr_E), .md_busy(md_busy),
    .md_done(md_done), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rtype(input int fn, input int rs, input int rt, input int rd);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
  endfunction
  function automatic logic [31:0] itype(input int op, input int rs, input int rt, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  // Reference view of an instruction: what it writes, when the value exists,
  // what it reads and by when it needs it (-1 = not read).
  function automatic void bdec(input logic [31:0] ir, output int dst, output int rdy_e,
                               output int rdy_m, output int sa, output int need_a,
                               output int sb, output int need_b, output bit hilo,
                               output int md_len);
    int op, fn;
    op = int'(ir[31:26]); fn = int'(ir[5:0]);
    dst = 0; rdy_e = 0; rdy_m = 0; hilo = 0; md_len = 0;
    sa = int'(ir[25:21]); sb = int'(ir[20:16]); need_a = -1; need_b = -1;
    if (op == 0 && (fn == 'h21 || fn == 'h23)) begin
      dst = int'(ir[15:11]); rdy_e = 1; need_a = 1; need_b = 1;
    end else if (op == 0 && fn == 'h08) need_a = 0;
    else if (op == 0 && fn >= 'h18 && fn <= 'h1b) begin
      need_a = 1; need_b = 1; hilo = 1; md_len = (fn >= 'h1a) ? 10 : 5;
    end else if (op == 0 && (fn == 'h10 || fn == 'h12)) begin
      dst = int'(ir[15:11]); rdy_e = 1; hilo = 1;
    end else if (op == 0 && (fn == 'h11 || fn == 'h13)) begin
      need_a = 1; hilo = 1;
    end else if (op == 'h0d) begin dst = sb; rdy_e = 1; need_a = 1; end
    else if (op == 'h0f) begin dst = sb; rdy_e = 1; end
    else if (op == 'h23) begin dst = sb; rdy_e = 2; rdy_m = 1; need_a = 1; end
    else if (op == 'h2b) begin need_a = 1; need_b = 2; end
    else if (op == 'h04) begin need_a = 0; need_b = 0; end
    else if (op == 'h03) dst = 31;
  endfunction

  // Model state: current cycle, last busy cycle, cycle of the done pulse.
  int          cyc = 0;
  int          busy_end = -100;
  int          done_at = -100;
  logic [31:0] m_count = 32'd0;

  always @(negedge clk) begin
    int  d_dst, d_re, d_rm, d_sa, d_na, d_sb, d_nb, d_ml;
    int  e_dst, e_re, e_rm, e_sa, e_na, e_sb, e_nb, e_ml;
    int  m_dst, m_re, m_rm, m_sa, m_na, m_sb, m_nb, m_ml;
    bit  d_hl, e_hl, m_hl, hz, busy, st;
    if (reset) begin
      busy_end = -100; done_at = -100; m_count = 32'd0;
    end else begin
      bdec(IR_D, d_dst, d_re, d_rm, d_sa, d_na, d_sb, d_nb, d_hl, d_ml);
      bdec(IR_E, e_dst, e_re, e_rm, e_sa, e_na, e_sb, e_nb, e_hl, e_ml);
      bdec(IR_M, m_dst, m_re, m_rm, m_sa, m_na, m_sb, m_nb, m_hl, m_ml);
      hz = 0;
      if (d_na >= 0 && d_sa != 0 && ((d_sa == e_dst && e_re > d_na) || (d_sa == m_dst && m_rm > d_na))) hz = 1;
      if (d_nb >= 0 && d_sb != 0 && ((d_sb == e_dst && e_re > d_nb) || (d_sb == m_dst && m_rm > d_nb))) hz = 1;
      busy = (e_ml > 0) || (cyc <= busy_end);
      st   = hz || (d_hl && busy);
      chk("model en_PC", 32'(en_PC), 32'(!st));
      chk("model en_D", 32'(en_D), 32'(!st));
      chk("model clr_E", 32'(clr_E), 32'(st));
      chk("model md_busy", 32'(md_busy), 32'(busy));
      chk("model md_done", 32'(md_done), 32'(cyc == done_at));
      chk("model stall_cycles", stall_cycles, m_count);
      if (e_ml > 0) begin busy_end = cyc + e_ml; done_at = busy_end + 1; end
      if (st && m_count != 32'hFFFF_FFFF) m_count = m_count + 32'd1;
    end
    cyc++;
  end

  task automatic step(input logic [31:0] d, input logic [31:0] e, input logic [31:0] m);
    @(posedge clk);
    #1;
    IR_D = d; IR_E = e; IR_M = m;
    #1;
  endtask

  logic [31:0] lw8, addu981, addu312, beq30, jal_i, jr31, lw0, addu200, addu512, sw5, sw_b8, lw88;
  logic [31:0] mult12, mfhi4, div12, mflo4;

  initial begin
    lw8     = itype('h23, 0, 8, 0);
    addu981 = rtype('h21, 8, 1, 9);
    addu312 = rtype('h21, 1, 2, 3);
    beq30   = itype('h04, 3, 0, 4);
    jal_i   = {6'h03, 26'h10};
    jr31    = rtype('h08, 31, 0, 0);
    lw0     = itype('h23, 1, 0, 0);
    addu200 = rtype('h21, 0, 0, 2);
    addu512 = rtype('h21, 1, 2, 5);
    sw5     = itype('h2b, 0, 5, 4);
    lw88    = itype('h23, 0, 8, 0);
    sw_b8   = itype('h2b, 8, 0, 0);
    mult12  = rtype('h18, 1, 2, 0);
    mfhi4   = rtype('h10, 0, 0, 4);
    div12   = rtype('h1a, 1, 2, 0);
    mflo4   = rtype('h12, 0, 0, 4);

    reset = 1'b1; IR_D = '0; IR_E = '0; IR_M = '0;
    repeat (2) @(posedge clk);
    #2;
    chk("reset en_PC", 32'(en_PC), 32'd1);
    chk("reset clr_E", 32'(clr_E), 32'd0);
    chk("reset md_busy", 32'(md_busy), 32'd0);
    chk("reset stall_cycles", stall_cycles, 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    // Load-use then forwarded from M.
    step(addu981, lw8, '0);
    chk("loaduse en_PC", 32'(en_PC), 32'd0);
    chk("loaduse clr_E", 32'(clr_E), 32'd1);
    step(addu981, '0, lw8);
    chk("loaduse M en_D", 32'(en_D), 32'd1);
    chk("loaduse count", stall_cycles, 32'd1);

    // Branch needs operand in D.
    step(beq30, addu312, '0);
    chk("beq E stall", 32'(clr_E), 32'd1);
    step(beq30, '0, addu312);
    chk("beq M no stall", 32'(clr_E), 32'd0);
    step(jr31, jal_i, '0);
    chk("jr after jal", 32'(en_PC), 32'd1);

    // Zero register and late store-data use.
    step(addu200, lw0, '0);
    chk("zero reg", 32'(en_PC), 32'd1);
    step(sw5, addu512, '0);
    chk("sw data alu", 32'(en_PC), 32'd1);
    step(itype('h2b, 0, 8, 0), lw88, '0);
    chk("sw data lw", 32'(en_PC), 32'd1);
    step(sw_b8, lw88, '0);
    chk("sw base lw", 32'(en_PC), 32'd0);

    // Multiply: 6 stall cycles, done on the 7th.
    step(mfhi4, mult12, '0);
    chk("mult start busy", 32'(md_busy), 32'd1);
    chk("mult start stall", 32'(en_PC), 32'd0);
    for (int i = 1; i <= 5; i++) step(mfhi4, '0, '0);
    chk("mult t+5 busy", 32'(md_busy), 32'd1);
    step(mfhi4, '0, '0);
    chk("mult t+6 done", 32'(md_done), 32'd1);
    chk("mult t+6 go", 32'(en_PC), 32'd1);
    chk("mult count", stall_cycles, 32'd9);

    // Divide: 11 stall cycles.
    step(mflo4, div12, '0);
    for (int i = 1; i <= 10; i++) step(mflo4, '0, '0);
    chk("div t+10 stall", 32'(en_PC), 32'd0);
    step(mflo4, '0, '0);
    chk("div t+11 done", 32'(md_done), 32'd1);
    chk("div count", stall_cycles, 32'd20);

    // Reset in the middle of a divide, counter at 6.
    step(mflo4, div12, '0);
    for (int i = 1; i <= 5; i++) step(mflo4, '0, '0);
    chk("pre-reset busy", 32'(md_busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("async md_busy", 32'(md_busy), 32'd0);
    chk("async en_PC", 32'(en_PC), 32'd1);
    chk("async stall_cycles", stall_cycles, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; IR_D = mflo4; IR_E = '0; IR_M = '0;
    #1;
    chk("post-reset mflo", 32'(en_PC), 32'd1);

    // Saturation from a preloaded counter.
    step(addu981, lw8, '0);
    force dut.r_stall_cycles = 32'hFFFF_FFFE;
    m_count = 32'hFFFF_FFFE;
    #1 release dut.r_stall_cycles;
    step(addu981, lw8, '0);
    chk("sat reach", stall_cycles, 32'hFFFF_FFFF);
    step(addu981, lw8, '0);
    step('0, '0, '0);
    chk("sat hold", stall_cycles, 32'hFFFF_FFFF);
    @(negedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
